// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller between the cpu data port and the
// on-chip data array. It adds a req/ready handshake, WAIT_STATES extra
// cycles of latency, byte-enabled writes and an error response for
// misaligned or out-of-range addresses.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   reset        asynchronous, active-high reset
//   req          request strobe, sampled only in IDLE
//   we           1 = write, 0 = read, sampled with req
//   addr         byte address, sampled with req
//   wdata        write data, sampled with req
//   be           byte enables for writes, ignored on reads
//   rdata        read data, valid only while ready=1, holds afterwards
//   ready        one-cycle response pulse
//   err          error flag, valid only while ready=1
//   busy         high from the acceptance edge until the cycle after ready
//   stat_stalls  cycles with busy=1 and ready=0, saturating
//
// Optional feature: define DMEM_CTRL_STATS_EN to build the stall counter;
// without it stat_stalls is tied to zero.
//
// DEPTH must be a power of two and at least 2; DATA_WIDTH a multiple of 8.
module dmem_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] be,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    ready,
  output logic                    err,
  output logic                    busy,
  output logic [31:0]             stat_stalls
);

  localparam int WB    = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(WB);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int LIM_W = OFF_W + IDX_W;

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(WB - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO  = {ADDR_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO  = {DATA_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [WB-1:0]           be_q, be_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;

  // The array is deliberately not reset.
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Operation seen on the RESP entry edge. With no wait states that edge is
  // the acceptance edge itself, so the live inputs are used instead of the
  // latched copy.
  logic                    resp_entry_s;
  logic                    op_we_s;
  logic [ADDR_WIDTH-1:0]   op_addr_s;
  logic [DATA_WIDTH-1:0]   op_wdata_s;
  logic [WB-1:0]           op_be_s;
  logic [IDX_W-1:0]        op_idx_s;
  logic                    addr_err_s;
  logic                    mem_we_s;

  // State register plus latched request and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= ADDR_ZERO;
      wdata_q <= DATA_ZERO;
      be_q    <= {WB{1'b0}};
      rdata_q <= DATA_ZERO;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: acceptance, wait countdown, single-cycle response
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          be_d    = be;
          cnt_d   = 4'(WAIT_STATES);
          if (WAIT_STATES != 32'sd0) begin
            state_d = WAIT;
          end else begin
            state_d = RESP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // The edge on which the count is down to 1 is the RESP entry edge.
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand selection and address checking for the RESP entry edge
  always_comb begin
    resp_entry_s = (state_d == RESP) && (state_q != RESP);
    if (state_q == IDLE) begin
      op_we_s    = we;
      op_addr_s  = addr;
      op_wdata_s = wdata;
      op_be_s    = be;
    end else begin
      op_we_s    = we_q;
      op_addr_s  = addr_q;
      op_wdata_s = wdata_q;
      op_be_s    = be_q;
    end
    op_idx_s   = op_addr_s[LIM_W-1:OFF_W];
    // Misaligned, or any bit above the array span set.
    addr_err_s = ((op_addr_s & ALIGN_MASK) != ADDR_ZERO) ||
                 ((op_addr_s >> LIM_W) != ADDR_ZERO);
  end

  // Output logic: response data, flags and array write enable
  always_comb begin
    rdata_d  = rdata_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    busy_d   = (state_d != IDLE);
    mem_we_s = 1'b0;
    if (resp_entry_s) begin
      ready_d = 1'b1;
      err_d   = addr_err_s;
      if (addr_err_s) begin
        rdata_d = DATA_ZERO;
      end else if (op_we_s) begin
        rdata_d  = DATA_ZERO;
        mem_we_s = 1'b1;
      end else begin
        rdata_d = mem[op_idx_s];
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Byte-enabled array write; blocked while reset is asserted so an
  // uncommitted write is dropped
  always_ff @(posedge clk) begin
    if (mem_we_s && !reset) begin
      for (int b = 0; b < WB; b++) begin
        if (op_be_s[b]) begin
          mem[op_idx_s][b*8 +: 8] <= op_wdata_s[b*8 +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = busy_q;

`ifdef DMEM_CTRL_STATS_EN
  logic [31:0] stat_stalls_q, stat_stalls_d;

  // Stall counter next value, saturating at all-ones
  always_comb begin
    if (busy_q && !ready_q && (stat_stalls_q != 32'hFFFF_FFFF)) begin
      stat_stalls_d = stat_stalls_q + 32'd1;
    end else begin
      stat_stalls_d = stat_stalls_q;
    end
  end

  // Stall counter register, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_stalls_q <= 32'd0;
    end else begin
      stat_stalls_q <= stat_stalls_d;
    end
  end

  assign stat_stalls = stat_stalls_q;
`else
  assign stat_stalls = 32'd0;
`endif

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised data-memory controller; successor to the fixed single-cycle dmem attached to the cpu in the computer top level.
- Adds a req/ready handshake, configurable wait states, byte-enabled writes and an error response.
- Sits between the cpu data port and the on-chip data array. The cpu stalls while `busy` is high.

Parameters:
- DATA_WIDTH, 32: data bus width in bits. Must be a multiple of 8.
- ADDR_WIDTH, 32: byte-address width.
- DEPTH, 64: number of DATA_WIDTH words in the array. Must be a power of 2.
- WAIT_STATES, 2: extra cycles between acceptance and response. Legal range 0..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  request strobe (level). Sampled only in IDLE.
- we  in  1  1 = write, 0 = read. Sampled with req.
- addr  in  ADDR_WIDTH  byte address. Sampled with req.
- wdata  in  DATA_WIDTH  write data. Sampled with req.
- be  in  DATA_WIDTH/8  byte enables for writes; ignored on reads.
- rdata  out  DATA_WIDTH  read data. Valid only while ready=1.
- ready  out  1  one-cycle response pulse.
- err  out  1  error flag. Valid only while ready=1.
- busy  out  1  high from the acceptance edge until the cycle after ready.
- stat_stalls  out  32  stall-cycle counter. Present only with the optional feature.

Behaviour:
- Reset values: state=IDLE; rdata=0; ready=0; err=0; busy=0; stat_stalls=0. Array contents are not cleared by reset.
- Word size: WB = DATA_WIDTH/8 bytes. Word index = addr / WB, i.e. addr bits [log2(DEPTH)+log2(WB)-1 : log2(WB)].
- States: IDLE, WAIT, RESP.
- IDLE:
  - If req=1 on an edge, latch we/addr/wdata/be, load wait counter with WAIT_STATES, and set busy=1.
  - Next state: WAIT if WAIT_STATES>0, else RESP.
  - If req=0, remain in IDLE.
- WAIT:
  - Counter decrements each cycle.
  - On the edge where the counter reaches 1, go to RESP.
  - req, we, addr, wdata and be are ignored in this state.
- Entering RESP (single edge):
  - Error check: err=1 if addr is not WB-aligned, or addr >= DEPTH*WB.
  - On error: no array access; rdata=0.
  - Valid write: update only the bytes whose be bit is 1; rdata=0.
  - Valid read: rdata = array word.
  - ready=1.
- RESP: ready=1 for exactly one cycle. Next state IDLE; ready and err return to 0 and busy drops to 0.
- Latency: with WAIT_STATES=N, ready rises N+1 cycles after the accepting edge. N=0 gives ready on the cycle immediately after acceptance.
- Back-to-back: a req held through RESP is re-accepted on the first IDLE edge. Minimum issue interval is N+2 cycles.
- rdata holds its last value after ready falls. Consumers must sample only on ready.
- Write with be=0: legal; array unchanged; err=0; ready pulses normally.
- Reset mid-operation: immediate return to IDLE; all outputs go to reset values. A write not yet committed (reset asserted before the RESP entry edge) is dropped.
- Reset asserted on the same edge as a req: no acceptance.

Optional Feature:
- Macro: DMEM_CTRL_STATS_EN.
- Defined:
  - stat_stalls is a 32-bit counter that increments on every cycle with busy=1 and ready=0.
  - It saturates at 0xFFFFFFFF and clears only on reset.
- Undefined: no counter logic; stat_stalls is tied to 0.

Test Plan:
- Reset, then hold req=0 for 5 cycles -> ready=0, busy=0, rdata=0, err=0 throughout.
- WAIT_STATES=2: write addr=0x10, wdata=0xDEADBEEF, be=0xF; then read addr=0x10 -> each ready exactly 3 cycles after acceptance; read rdata=0xDEADBEEF; err=0.
- Byte enables: write 0xDEADBEEF to 0x10, then write 0x11223344 with be=0x5, then read -> rdata=0xDE22BE44.
- Errors: read addr=0x12 -> err=1, rdata=0. Write addr=0x100 (DEPTH=64) -> err=1 and array unchanged; a following read of 0x0 returns the prior value.
- WAIT_STATES=0 with req held high for 6 cycles -> ready on every 2nd cycle; busy low only in the cycles after ready.
- Reset during WAIT of a write to 0x20 (prior value 0x0) -> outputs at reset values immediately; a subsequent read of 0x20 returns 0x0.
- Stats: with DMEM_CTRL_STATS_EN and WAIT_STATES=2, perform 3 transactions -> stat_stalls=6. Without the macro -> stat_stalls=0.
